// File: rtl/fp16_mul_sched_if.sv
// Handshake/bus bundle for fp16_mul_sched.
//   REQ0_*/REQ1_* : two requesters, valid/ready, FP16 operand pairs A/B.
//   CORE_*        : unpacked operands to the shared magnitude multiplier core
//                   and its result/flags coming back.
//   RSP_*         : tagged response, valid/ready.
// slave  : the scheduler's view (requests in, core operands out, response out).
// master : the environment's view (requesters, core, response consumer).
interface fp16_mul_sched_if;
    logic        REQ0_VALID;
    logic        REQ0_READY;
    logic [15:0] REQ0_A;
    logic [15:0] REQ0_B;
    logic        REQ1_VALID;
    logic        REQ1_READY;
    logic [15:0] REQ1_A;
    logic [15:0] REQ1_B;
    logic        CORE_SIGN_A;
    logic        CORE_SIGN_B;
    logic [4:0]  CORE_EXP_A;
    logic [4:0]  CORE_EXP_B;
    logic [10:0] CORE_MANT_A;
    logic [10:0] CORE_MANT_B;
    logic [15:0] CORE_Q;
    logic [4:0]  CORE_FLAGS;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic        RSP_ID;
    logic [15:0] RSP_Q;
    logic [4:0]  RSP_FLAGS;

    modport slave (
        input  REQ0_VALID, REQ0_A, REQ0_B,
        input  REQ1_VALID, REQ1_A, REQ1_B,
        input  CORE_Q, CORE_FLAGS, RSP_READY,
        output REQ0_READY, REQ1_READY,
        output CORE_SIGN_A, CORE_SIGN_B, CORE_EXP_A, CORE_EXP_B,
        output CORE_MANT_A, CORE_MANT_B,
        output RSP_VALID, RSP_ID, RSP_Q, RSP_FLAGS
    );

    modport master (
        output REQ0_VALID, REQ0_A, REQ0_B,
        output REQ1_VALID, REQ1_A, REQ1_B,
        output CORE_Q, CORE_FLAGS, RSP_READY,
        input  REQ0_READY, REQ1_READY,
        input  CORE_SIGN_A, CORE_SIGN_B, CORE_EXP_A, CORE_EXP_B,
        input  CORE_MANT_A, CORE_MANT_B,
        input  RSP_VALID, RSP_ID, RSP_Q, RSP_FLAGS
    );
endinterface

// File: rtl/fp16_mul_sched.sv
// Two-requester round-robin scheduler/sequencer for a shared FP16 magnitude
// multiplier core.
//   CLK  : rising-edge clock.
//   RST  : synchronous active-high reset; drops any in-flight operation.
//   bus  : fp16_mul_sched_if.slave carrying the two request ports, the core
//          operand/result ports and the response port.
// Special operands (NaN, Inf, zero) are resolved locally and answered the
// cycle after acceptance; all other pairs are unpacked onto the core, which
// is given CORE_LAT cycles before its result is captured.
module fp16_mul_sched #(
    parameter int unsigned CORE_LAT = 1
) (
    input logic              CLK,
    input logic              RST,
    fp16_mul_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LAT_INIT = 4'(CORE_LAT);

    state_t      state;
    state_t      state_nxt;
    logic        ptr;
    logic [3:0]  cnt;

    logic [1:0]  req_valid;
    logic        gnt_valid;
    logic        gnt_id;
    logic [15:0] op_a;
    logic [15:0] op_b;

    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        special;
    logic        prod_sign;
    logic [15:0] sp_q;
    logic [4:0]  sp_flags;

    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_q;
    logic [4:0]  rsp_flags;
    logic        core_sign_a, core_sign_b;
    logic [4:0]  core_exp_a, core_exp_b;
    logic [10:0] core_mant_a, core_mant_b;

    // Reserved flag bit from the core is never forwarded.
    logic        flags_unused;
    assign flags_unused = bus.CORE_FLAGS[3];

    assign req_valid = {bus.REQ1_VALID, bus.REQ0_VALID};

    // Grant: pointer's requester first, otherwise the other one. Only in IDLE
    // and never while reset is asserted, so READY stays low under reset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ptr;
        if (state == IDLE && !RST) begin
            if (req_valid[ptr]) begin
                gnt_valid = 1'b1;
                gnt_id    = ptr;
            end else if (req_valid[~ptr]) begin
                gnt_valid = 1'b1;
                gnt_id    = ~ptr;
            end
        end
    end

    assign bus.REQ0_READY = gnt_valid && !gnt_id;
    assign bus.REQ1_READY = gnt_valid &&  gnt_id;

    assign op_a = gnt_id ? bus.REQ1_A : bus.REQ0_A;
    assign op_b = gnt_id ? bus.REQ1_B : bus.REQ0_B;

    // Operand classification of the granted pair.
    always_comb begin
        nan_a     = (&op_a[14:10]) && (|op_a[9:0]);
        nan_b     = (&op_b[14:10]) && (|op_b[9:0]);
        inf_a     = (&op_a[14:10]) && !(|op_a[9:0]);
        inf_b     = (&op_b[14:10]) && !(|op_b[9:0]);
        zero_a    = !(|op_a[14:0]);
        zero_b    = !(|op_b[14:0]);
        special   = nan_a || nan_b || inf_a || inf_b || zero_a || zero_b;
        prod_sign = op_a[15] ^ op_b[15];
        sp_flags  = '0;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            sp_q     = 16'h7E00;
            sp_flags = 5'b10000;
        end else if (inf_a || inf_b) begin
            sp_q = {prod_sign, 5'h1F, 10'h000};
        end else begin
            sp_q = {prod_sign, 15'h0000};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_valid) state_nxt = special ? RESP : BUSY;
            BUSY: if (cnt == 4'd1) state_nxt = RESP;
            RESP: if (bus.RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr         <= 1'b0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_q       <= '0;
            rsp_flags   <= '0;
            core_sign_a <= 1'b0;
            core_sign_b <= 1'b0;
            core_exp_a  <= '0;
            core_exp_b  <= '0;
            core_mant_a <= '0;
            core_mant_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        ptr    <= ~gnt_id;
                        rsp_id <= gnt_id;
                        if (special) begin
                            rsp_q     <= sp_q;
                            rsp_flags <= sp_flags;
                            rsp_valid <= 1'b1;
                        end else begin
                            // Subnormals share the exponent of the smallest
                            // normal; the hidden bit carries the difference.
                            core_sign_a <= op_a[15];
                            core_sign_b <= op_b[15];
                            core_exp_a  <= (op_a[14:10] == 5'd0) ? 5'd1 : op_a[14:10];
                            core_exp_b  <= (op_b[14:10] == 5'd0) ? 5'd1 : op_b[14:10];
                            core_mant_a <= {(op_a[14:10] != 5'd0), op_a[9:0]};
                            core_mant_b <= {(op_b[14:10] != 5'd0), op_b[9:0]};
                            cnt         <= LAT_INIT;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_q     <= bus.CORE_Q;
                        rsp_flags <= {bus.CORE_FLAGS[4], 1'b0, bus.CORE_FLAGS[2:0]};
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.RSP_READY) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.RSP_VALID   = rsp_valid;
    assign bus.RSP_ID      = rsp_id;
    assign bus.RSP_Q       = rsp_q;
    assign bus.RSP_FLAGS   = rsp_flags;
    assign bus.CORE_SIGN_A = core_sign_a;
    assign bus.CORE_SIGN_B = core_sign_b;
    assign bus.CORE_EXP_A  = core_exp_a;
    assign bus.CORE_EXP_B  = core_exp_b;
    assign bus.CORE_MANT_A = core_mant_a;
    assign bus.CORE_MANT_B = core_mant_b;
endmodule

// File: tb/tb_fp16_mul_sched.sv
// Self-checking bench for fp16_mul_sched: one instance with CORE_LAT=2 driven
// from a vector table with a response scoreboard, and one with CORE_LAT=4 for
// the reset-while-busy sequence.
module tb_fp16_mul_sched;
    localparam int unsigned LAT  = 2;
    localparam int unsigned LAT4 = 4;

    logic CLK = 1'b0;
    logic RST;
    logic RST4;
    always #5 CLK = ~CLK;

    fp16_mul_sched_if b ();
    fp16_mul_sched_if b4 ();

    fp16_mul_sched #(.CORE_LAT(LAT))  u_dut  (.CLK(CLK), .RST(RST),  .bus(b));
    fp16_mul_sched #(.CORE_LAT(LAT4)) u_dut4 (.CLK(CLK), .RST(RST4), .bus(b4));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Core model: arbitrary but deterministic function of the core ports,
    // delivered LAT-1 clocks after the operands (one pipeline stage here).
    function automatic logic [20:0] core_fn(input logic sa, input logic sb,
                                            input logic [4:0] ea, input logic [4:0] eb,
                                            input logic [10:0] ma, input logic [10:0] mb);
        logic [4:0] e;
        e = ea + eb - 5'd15;
        return {sa ^ sb, e, ma[9:0] ^ mb[9:0], ma[4:0] ^ mb[4:0]};
    endfunction

    logic [20:0] core_pipe;
    always @(posedge CLK)
        core_pipe <= core_fn(b.CORE_SIGN_A, b.CORE_SIGN_B, b.CORE_EXP_A, b.CORE_EXP_B,
                             b.CORE_MANT_A, b.CORE_MANT_B);
    assign b.CORE_Q     = core_pipe[20:5];
    assign b.CORE_FLAGS = core_pipe[4:0];
    assign b4.CORE_Q     = 16'h1234;
    assign b4.CORE_FLAGS = 5'h1F;

    // {sign, exp, mant-with-hidden-bit} as the core ports should show it.
    function automatic logic [16:0] unpack(input logic [15:0] x);
        logic [4:0] e;
        e = x[14:10];
        return {x[15], (e == 5'd0) ? 5'd1 : e, (e != 5'd0), x[9:0]};
    endfunction

    typedef struct packed {
        logic        id;
        logic [15:0] q;
        logic [4:0]  f;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        special;
        logic [15:0] q;
        logic [4:0]  f;
    } vec_t;
    vec_t vecs[11];

    logic [33:0] exp_core;

    // Scoreboard consumer: every accepted response must match the oldest entry.
    always @(negedge CLK) begin
        rsp_t e;
        if (!RST && b.RSP_VALID && b.RSP_READY) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", b.RSP_ID, e.id);
                check("rsp_q", b.RSP_Q, e.q);
                check("rsp_flags", b.RSP_FLAGS, e.f);
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [15:0] a, input logic [15:0] bb);
        if (id) begin
            b.REQ1_VALID = v; b.REQ1_A = a; b.REQ1_B = bb;
        end else begin
            b.REQ0_VALID = v; b.REQ0_A = a; b.REQ0_B = bb;
        end
    endtask

    // One operation from a single requester; hold>0 back-pressures the
    // response for that many cycles while the other requester is asking.
    task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] bb,
                         input logic special, input logic [15:0] eq, input logic [4:0] ef,
                         input int hold);
        int   t;
        logic got;
        rsp_t e;
        b.RSP_READY = (hold == 0);
        set_req(id, 1'b1, a, bb);
        got = 1'b0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge CLK);
            got = id ? b.REQ1_READY : b.REQ0_READY;
        end
        check("grant", got, 1);
        if (!got) begin
            set_req(id, 1'b0, a, bb);
            return;
        end
        e.id = id; e.q = eq; e.f = ef;
        sb.push_back(e);
        if (!special) exp_core = {unpack(a), unpack(bb)};
        @(posedge CLK); #1;
        set_req(id, 1'b0, a, bb);
        check("core_ports", {b.CORE_SIGN_A, b.CORE_EXP_A, b.CORE_MANT_A,
                             b.CORE_SIGN_B, b.CORE_EXP_B, b.CORE_MANT_B}, exp_core);
        t = 1;
        while (!b.RSP_VALID && t < 40) begin
            @(posedge CLK); #1;
            t++;
        end
        check("rsp_latency", t, special ? 1 : LAT + 1);
        if (hold > 0) begin
            set_req(~id, 1'b1, 16'h3C00, 16'h3C00);
            for (int i = 0; i < hold; i++) begin
                check("bp_valid", b.RSP_VALID, 1);
                check("bp_q", b.RSP_Q, eq);
                check("bp_id", b.RSP_ID, id);
                check("bp_req_ready", {b.REQ0_READY, b.REQ1_READY}, 0);
                @(posedge CLK); #1;
            end
            set_req(~id, 1'b0, 16'h0, 16'h0);
            b.RSP_READY = 1'b1;
        end
        @(posedge CLK); #1;
        check("rsp_valid_drop", b.RSP_VALID, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int          ops;
        logic [3:0]  ids;
        logic        got;
        logic        seen;
        rsp_t        e;

        vecs[0]  = '{1'b0, 16'h3C00, 16'h4000, 1'b0, 16'h4000, 5'h00};
        vecs[1]  = '{1'b1, 16'h7E00, 16'h3C00, 1'b1, 16'h7E00, 5'h10};
        vecs[2]  = '{1'b0, 16'h7C00, 16'h8000, 1'b1, 16'h7E00, 5'h10};
        vecs[3]  = '{1'b1, 16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 5'h00};
        vecs[4]  = '{1'b0, 16'h0000, 16'h7C01, 1'b1, 16'h7E00, 5'h10};
        vecs[5]  = '{1'b1, 16'h8000, 16'h3C00, 1'b1, 16'h8000, 5'h00};
        vecs[6]  = '{1'b0, 16'h7C00, 16'h7C00, 1'b1, 16'h7C00, 5'h00};
        vecs[7]  = '{1'b1, 16'h0005, 16'hC123, 1'b0, 16'h8926, 5'h06};
        vecs[8]  = '{1'b0, 16'h3555, 16'h3AAA, 1'b0, 16'h33FF, 5'h17};
        vecs[9]  = '{1'b1, 16'h03FF, 16'h0001, 1'b0, 16'h4FFE, 5'h16};
        vecs[10] = '{1'b0, 16'h3C00, 16'hFE00, 1'b1, 16'h7E00, 5'h10};

        // Reset with both requesters asking: nothing may be granted.
        RST = 1'b1; RST4 = 1'b1;
        exp_core = '0;
        b.RSP_READY = 1'b1;
        set_req(1'b0, 1'b1, 16'h3C00, 16'h3C00);
        set_req(1'b1, 1'b1, 16'h3C00, 16'h3C00);
        b4.REQ0_VALID = 1'b0; b4.REQ0_A = '0; b4.REQ0_B = '0;
        b4.REQ1_VALID = 1'b0; b4.REQ1_A = '0; b4.REQ1_B = '0;
        b4.RSP_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_outputs", {b.REQ0_READY, b.REQ1_READY,
                                b.CORE_SIGN_A, b.CORE_EXP_A, b.CORE_MANT_A,
                                b.CORE_SIGN_B, b.CORE_EXP_B, b.CORE_MANT_B,
                                b.RSP_VALID, b.RSP_ID, b.RSP_Q, b.RSP_FLAGS}, 0);
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 16'h0, 16'h0);
        RST = 1'b0; RST4 = 1'b0;
        @(posedge CLK); #1;

        foreach (vecs[i])
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].special, vecs[i].q, vecs[i].f, 0);

        do_op(vecs[8].id, vecs[8].a, vecs[8].b, 1'b0, vecs[8].q, vecs[8].f, 5);

        // Arbitration from reset: both requesters asking continuously.
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_core = '0;
        b.RSP_READY = 1'b1;
        set_req(1'b0, 1'b1, vecs[0].a, vecs[0].b);
        set_req(1'b1, 1'b1, vecs[1].a, vecs[1].b);
        ops = 0;
        ids = '0;
        for (int c = 0; c < 100 && ops < 4; c++) begin
            @(negedge CLK);
            check("one_ready", b.REQ0_READY & b.REQ1_READY, 0);
            if (b.REQ0_READY || b.REQ1_READY) begin
                ids[ops] = b.REQ1_READY;
                e.id = b.REQ1_READY;
                e.q  = b.REQ1_READY ? vecs[1].q : vecs[0].q;
                e.f  = b.REQ1_READY ? vecs[1].f : vecs[0].f;
                sb.push_back(e);
                ops++;
            end
        end
        @(posedge CLK); #1;
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 16'h0, 16'h0);
        check("arb_ops", ops, 4);
        check("arb_sequence", ids, 4'b1010);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge CLK);
        #1;
        check("sb_drained", sb.size(), 0);

        // Reset during the second BUSY cycle of a CORE_LAT=4 operation.
        b4.REQ0_VALID = 1'b1; b4.REQ0_A = 16'h3C00; b4.REQ0_B = 16'h4000;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            got = b4.REQ0_READY;
        end
        check("r4_grant0", got, 1);
        @(posedge CLK); #1;
        b4.REQ0_VALID = 1'b0;
        check("r4_core_exp", {b4.CORE_EXP_A, b4.CORE_EXP_B}, {5'd15, 5'd16});
        @(posedge CLK); #1;
        RST4 = 1'b1;
        @(posedge CLK); #1;
        check("r4_outputs_zero", {b4.REQ0_READY, b4.REQ1_READY,
                                  b4.CORE_SIGN_A, b4.CORE_EXP_A, b4.CORE_MANT_A,
                                  b4.CORE_SIGN_B, b4.CORE_EXP_B, b4.CORE_MANT_B,
                                  b4.RSP_VALID, b4.RSP_ID, b4.RSP_Q, b4.RSP_FLAGS}, 0);
        RST4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            seen = seen | b4.RSP_VALID;
        end
        check("r4_no_rsp", seen, 0);
        b4.REQ1_VALID = 1'b1; b4.REQ1_A = 16'h7C00; b4.REQ1_B = 16'h3C00;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            got = b4.REQ1_READY;
        end
        check("r4_grant1", got, 1);
        @(posedge CLK); #1;
        b4.REQ1_VALID = 1'b0;
        check("r4_rsp", {b4.RSP_VALID, b4.RSP_ID, b4.RSP_Q, b4.RSP_FLAGS},
              {1'b1, 1'b1, 16'h7C00, 5'h00});
        @(posedge CLK); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp16_mul_sched.md
Name: fp16_mul_sched

Overview:
- Two-requester round-robin scheduler and sequencer for the shared half-precision magnitude multiplier core.
- Accepts FP16 operand pairs over valid/ready, unpacks them into sign/exponent/mantissa and drives the core.
- Resolves special operands (NaN, Inf, zero) without using the core.
- Waits the core latency, then returns the tagged result and flags over a valid/ready response port.

Parameters:
- CORE_LAT, 1, cycles between operands being stable on the core ports and CORE_Q/CORE_FLAGS being valid; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has an operand pair.
- REQ0_READY  output  1  requester 0 handshake accepted this cycle.
- REQ0_A, REQ0_B  input  16 each  requester 0 FP16 operands.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B  same as requester 0, for requester 1.
- CORE_SIGN_A, CORE_SIGN_B  output  1 each  operand signs to the core.
- CORE_EXP_A, CORE_EXP_B  output  5 each  operand exponents to the core.
- CORE_MANT_A, CORE_MANT_B  output  11 each  mantissas with hidden bit.
- CORE_Q  input  16  core result.
- CORE_FLAGS  input  5  core flags.
- RSP_VALID  output  1  response available.
- RSP_READY  input  1  consumer accepts the response.
- RSP_ID  output  1  requester that owns the response.
- RSP_Q  output  16  FP16 product.
- RSP_FLAGS  output  5  [4]=NV (invalid), [3]=reserved 0, [2]=UF, [1]=OF, [0]=INEXACT.

Behaviour:
- Reset:
  - While RST is high, all outputs are 0 and REQn_READY is 0.
  - State goes to IDLE and the round-robin pointer goes to requester 0.
  - Any in-flight operation is dropped with no response.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Grant goes to the pointer's requester if its VALID is high, else to the other requester if its VALID is high.
  - REQn_READY is combinational and high only for the granted requester.
  - Handshake occurs when VALID and READY are both high.
  - On handshake in cycle T: register the operands and the requester ID, and set the pointer to the non-granted requester.
- Operand classification, registered at handshake:
  - NaN: exp=31, frac!=0.
  - Inf: exp=31, frac=0.
  - Zero: exp=0, frac=0.
- Special path (at least one special operand): transition IDLE -> RESP directly; RSP_VALID=1 from cycle T+1. Result selection, in priority order:
  1. Any NaN, or Inf×zero: RSP_Q=16'h7E00, RSP_FLAGS=5'b10000.
  2. Any Inf: RSP_Q={sign,5'h1F,10'h0}, RSP_FLAGS=0.
  3. Any zero: RSP_Q={sign,15'h0}, RSP_FLAGS=0.
  - In all cases sign = A[15]^B[15].
- Core path:
  - Transition IDLE -> BUSY. The core operand outputs are registered and stable from cycle T+1 until leaving BUSY.
  - Hidden bit = (exp!=0).
  - Subnormal operands drive exponent 1; all others drive the raw exponent field.
  - A 4-bit counter loads CORE_LAT and decrements each BUSY cycle.
  - On the BUSY cycle where the counter equals 1, sample CORE_Q/CORE_FLAGS into RSP_Q/RSP_FLAGS and go to RESP.
  - RSP_VALID=1 from cycle T+1+CORE_LAT.
- RESP:
  - RSP_VALID, RSP_ID, RSP_Q and RSP_FLAGS are held stable until RSP_READY is high.
  - On handshake: RSP_VALID=0 next cycle, return to IDLE.
  - No new request is accepted in BUSY or RESP; REQn_READY=0 there.
  - Maximum throughput is one op per CORE_LAT+2 cycles for the core path, and one per 2 cycles for the special path.
- RSP_READY may be high before RSP_VALID; it has no effect outside RESP.
- A requester dropping VALID before its handshake loses its turn with no side effect.
- Core outputs keep their last value after leaving BUSY and are ignored outside BUSY.

Test Plan:
- Core path, CORE_LAT=2: REQ0 A=0x3C00, B=0x4000, core model returns 0x4000 and flags 0. Core ports show 0/15/0x400 and 0/16/0x400 from T+1. Response RSP_VALID=1 at T+3 with RSP_Q=0x4000, RSP_ID=0, RSP_FLAGS=0.
- Special path, NaN: REQ1 A=0x7E00, B=0x3C00 -> RSP_Q=0x7E00, RSP_FLAGS=0x10, RSP_ID=1, valid at T+1; core operands unchanged from previous op.
- Special path, Inf×zero: A=0x7C00, B=0x8000 -> RSP_Q=0x7E00, NV=1. Inf×finite: A=0xFC00, B=0x3C00 -> RSP_Q=0xFC00, RSP_FLAGS=0.
- Arbitration: both VALIDs held high for 4 ops -> RSP_ID sequence 0,1,0,1; only one READY is ever high per cycle.
- Backpressure: RSP_READY low for 5 cycles after RSP_VALID -> RSP_Q/RSP_ID stable and both REQn_READY low throughout; one cycle after RSP_READY=1, RSP_VALID=0.
- Reset mid-BUSY, CORE_LAT=4: assert RST during the counter's second BUSY cycle -> next cycle all outputs 0, no response ever produced; a following request from REQ1 alone is granted.
